// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch unit: widths, instruction field layout, FSM states.
package cpu_pkg;

  localparam int PC_W_DEF = 6;
  localparam int INSTR_W  = 10;

  localparam int OPC_HI = 9;
  localparam int OPC_LO = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 3;
  localparam int IMM_HI = 2;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2
  } fetchState_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface fetch_unit_if import cpu_pkg::*; #(
  parameter int PC_W = PC_W_DEF
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: load has priority over increment; increment wraps modulo 2^PC_W.
module pc_reg import cpu_pkg::*; #(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  // Select the next program counter: jump target, sequential successor, or hold.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  // Program counter register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: FETCH/WAIT/EXEC sequencer, instruction register and program counter.
module fetch_unit import cpu_pkg::*; #(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  input  logic            stall,
  input  logic            jmp_sel,
  output logic [3:0]      opcode,
  output logic [2:0]      rd,
  output logic [2:0]      imm,
  output logic            exec_valid,
  output logic [PC_W-1:0] pc
);

  fetchState_e        state_q;
  fetchState_e        state_d;
  logic [INSTR_W-1:0] ir_q;
  logic [INSTR_W-1:0] ir_d;
  logic               irLoad;
  logic               pcLoad;
  logic               pcInc;
  logic               reqOut;
  logic               execOut;
  logic [5:0]         jmpTarget;
  logic [PC_W-1:0]    pcLoadVal;
  logic [PC_W-1:0]    pcValue;

  // State register; reset aborts any instruction in flight and restarts in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack outside WAIT has no effect on sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  if (imem.imem_ack) state_d = ST_WAIT == ST_WAIT ? ST_EXEC : ST_WAIT;
      ST_EXEC:  if (!stall) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  // Per-state outputs; the request is masked while reset is held so it stays low.
  always_comb begin
    reqOut  = 1'b0;
    execOut = 1'b0;
    irLoad  = 1'b0;
    pcLoad  = 1'b0;
    pcInc   = 1'b0;
    case (state_q)
      ST_FETCH: reqOut = rst_n;
      ST_WAIT: begin
        reqOut = rst_n;
        irLoad = imem.imem_ack;
      end
      ST_EXEC: begin
        execOut = 1'b1;
        pcLoad  = !stall && jmp_sel;
        pcInc   = !stall && !jmp_sel;
      end
      default: ;
    endcase
  end

  // Instruction register next value: capture only on an ack seen in WAIT.
  always_comb begin
    ir_d = ir_q;
    if (irLoad) begin
      ir_d = imem.imem_rdata;
    end
  end

  // Instruction register; fields feed the control unit straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
    end else begin
      ir_q <= ir_d;
    end
  end

  assign opcode = ir_q[OPC_HI:OPC_LO];
  assign rd     = ir_q[RD_HI:RD_LO];
  assign imm    = ir_q[IMM_HI:IMM_LO];

  assign jmpTarget = {rd, imm};
  assign pcLoadVal = PC_W'(jmpTarget);

  pc_reg #(
    .PC_W(PC_W)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pcLoad),
    .inc     (pcInc),
    .load_val(pcLoadVal),
    .pc      (pcValue)
  );

  assign pc             = pcValue;
  assign exec_valid     = execOut;
  assign imem.imem_req  = reqOut;
  assign imem.imem_addr = pcValue;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       jmp_sel;
  logic [3:0] opcode;
  logic [2:0] rd;
  logic [2:0] imm;
  logic       exec_valid;
  logic [5:0] pc;

  int compareCount;
  int mismatchCount;
  int reqCycles;

  fetch_unit_if #(.PC_W(6)) imemBus ();

  fetch_unit #(
    .PC_W(6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem      (imemBus),
    .stall     (stall),
    .jmp_sel   (jmp_sel),
    .opcode    (opcode),
    .rd        (rd),
    .imm       (imm),
    .exec_valid(exec_valid),
    .pc        (pc)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive all bench-controlled inputs at once.
  task automatic applyStimulus(input logic ackVal, input logic [9:0] rdataVal, input logic stallVal, input logic jmpVal);
    imemBus.imem_ack   = ackVal;
    imemBus.imem_rdata = rdataVal;
    stall              = stallVal;
    jmp_sel            = jmpVal;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // From FETCH, run one fetch with waitCycles ack-less WAIT cycles; ends in EXEC.
  task automatic fetchInstr(input logic [9:0] word, input int waitCycles, output int reqSeen);
    reqSeen = 0;
    if (imemBus.imem_req) reqSeen++;
    tick;
    for (int i = 0; i < waitCycles; i++) begin
      if (imemBus.imem_req) reqSeen++;
      tick;
    end
    if (imemBus.imem_req) reqSeen++;
    checkOutput("ackCycleExecLow", 32'(exec_valid), 0);
    applyStimulus(1'b1, word, 1'b0, 1'b0);
    tick;
    applyStimulus(1'b0, 10'h155, 1'b0, 1'b0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenario sequence.
  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);
    repeat (3) tick;

    checkOutput("rstPc", 32'(pc), 0);
    checkOutput("rstOpcode", 32'(opcode), 0);
    checkOutput("rstRd", 32'(rd), 0);
    checkOutput("rstImm", 32'(imm), 0);
    checkOutput("rstExec", 32'(exec_valid), 0);
    checkOutput("rstReq", 32'(imemBus.imem_req), 0);

    rst_n = 1'b1;
    #1;
    checkOutput("firstReq", 32'(imemBus.imem_req), 1);
    checkOutput("firstAddr", 32'(imemBus.imem_addr), 0);

    fetchInstr(10'b0001_010_011, 0, reqCycles);
    checkOutput("i1ReqCycles", 32'(reqCycles), 2);
    checkOutput("i1Exec", 32'(exec_valid), 1);
    checkOutput("i1ReqLow", 32'(imemBus.imem_req), 0);
    checkOutput("i1Opcode", 32'(opcode), 1);
    checkOutput("i1Rd", 32'(rd), 2);
    checkOutput("i1Imm", 32'(imm), 3);
    checkOutput("i1PcHeld", 32'(pc), 0);
    tick;
    checkOutput("i1PcInc", 32'(pc), 1);
    checkOutput("i1NextAddr", 32'(imemBus.imem_addr), 1);
    checkOutput("i1NextReq", 32'(imemBus.imem_req), 1);
    checkOutput("i1ExecLow", 32'(exec_valid), 0);

    fetchInstr(10'b0010_101_110, 3, reqCycles);
    checkOutput("i2ReqCycles", 32'(reqCycles), 5);
    checkOutput("i2Exec", 32'(exec_valid), 1);
    checkOutput("i2Rd", 32'(rd), 5);
    checkOutput("i2Imm", 32'(imm), 6);
    checkOutput("i2PcHeld", 32'(pc), 1);
    applyStimulus(1'b0, 10'h155, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b0, 10'h155, 1'b0, 1'b0);
    checkOutput("i2JumpPc", 32'(pc), 46);
    checkOutput("i2JumpAddr", 32'(imemBus.imem_addr), 46);

    fetchInstr(10'b1111_011_001, 0, reqCycles);
    checkOutput("i3Opcode", 32'(opcode), 15);
    applyStimulus(1'b0, 10'h155, 1'b1, 1'b1);
    tick;
    checkOutput("stall1Exec", 32'(exec_valid), 1);
    checkOutput("stall1Pc", 32'(pc), 46);
    checkOutput("stall1Opcode", 32'(opcode), 15);
    applyStimulus(1'b0, 10'h155, 1'b1, 1'b0);
    tick;
    checkOutput("stall2Exec", 32'(exec_valid), 1);
    checkOutput("stall2Pc", 32'(pc), 46);
    applyStimulus(1'b1, 10'h000, 1'b1, 1'b1);
    tick;
    checkOutput("stall3Exec", 32'(exec_valid), 1);
    checkOutput("stall3Pc", 32'(pc), 46);
    checkOutput("execAckOpcode", 32'(opcode), 15);
    checkOutput("execAckRd", 32'(rd), 3);
    checkOutput("execAckImm", 32'(imm), 1);
    applyStimulus(1'b0, 10'h155, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b0, 10'h155, 1'b0, 1'b0);
    checkOutput("unstallJumpPc", 32'(pc), 25);
    checkOutput("unstallExecLow", 32'(exec_valid), 0);
    checkOutput("unstallAddr", 32'(imemBus.imem_addr), 25);

    fetchInstr(10'b0100_111_111, 0, reqCycles);
    applyStimulus(1'b0, 10'h155, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b0, 10'h155, 1'b0, 1'b0);
    checkOutput("jumpMaxPc", 32'(pc), 63);
    fetchInstr(10'b0101_000_000, 1, reqCycles);
    checkOutput("i5ReqCycles", 32'(reqCycles), 3);
    checkOutput("i5Opcode", 32'(opcode), 5);
    tick;
    checkOutput("wrapPc", 32'(pc), 0);
    checkOutput("wrapAddr", 32'(imemBus.imem_addr), 0);

    fetchInstr(10'b0110_001_100, 0, reqCycles);
    tick;
    checkOutput("i6Pc", 32'(pc), 1);
    tick;
    checkOutput("waitReq", 32'(imemBus.imem_req), 1);
    checkOutput("waitExecLow", 32'(exec_valid), 0);
    applyStimulus(1'b1, 10'b1010_101_010, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstPc", 32'(pc), 0);
    checkOutput("midRstOpcode", 32'(opcode), 0);
    checkOutput("midRstReq", 32'(imemBus.imem_req), 0);
    checkOutput("midRstExec", 32'(exec_valid), 0);
    tick;
    checkOutput("rstAckOpcode", 32'(opcode), 0);
    checkOutput("rstAckRd", 32'(rd), 0);
    checkOutput("rstAckPc", 32'(pc), 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 10'h155, 1'b0, 1'b0);
    #1;
    checkOutput("restartReq", 32'(imemBus.imem_req), 1);
    checkOutput("restartAddr", 32'(imemBus.imem_addr), 0);
    checkOutput("restartExec", 32'(exec_valid), 0);
    tick;
    checkOutput("restartWaitExec", 32'(exec_valid), 0);
    checkOutput("restartWaitReq", 32'(imemBus.imem_req), 1);
    checkOutput("restartWaitOpcode", 32'(opcode), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 6, program-counter width in bits.
REQ-002 Parameter INSTR_W, fixed 10, instruction width: opcode[9:6], rd[5:3], imm[2:0].
REQ-003 Port clk  in  1  single clock, rising-edge active.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port imem_req  out  1  instruction-memory read request, held until ack.
REQ-006 Port imem_addr  out  PC_W  fetch address, equals pc while imem_req is high.
REQ-007 Port imem_ack  in  1  memory response valid, single-cycle pulse.
REQ-008 Port imem_rdata  in  INSTR_W  instruction word, valid when imem_ack is high.
REQ-009 Port stall  in  1  downstream hold, keeps the current instruction presented.
REQ-010 Port jmp_sel  in  1  taken-jump decision from the control unit, sampled in EXEC.
REQ-011 Port opcode  out  4  registered instruction bits [9:6], drives the control-unit Opcode input.
REQ-012 Port rd  out  3  registered instruction bits [5:3].
REQ-013 Port imm  out  3  registered instruction bits [2:0].
REQ-014 Port exec_valid  out  1  high exactly while the FSM is in EXEC.
REQ-015 Port pc  out  PC_W  current program counter.

Function
REQ-016 FSM SHALL have three states: FETCH, WAIT, EXEC.
REQ-017 FETCH: assert imem_req with imem_addr = pc; next state WAIT unconditionally.
REQ-018 WAIT: keep imem_req high and imem_addr = pc; on imem_ack, capture imem_rdata into the IR and go to EXEC; otherwise stay.
REQ-019 imem_ack in FETCH or EXEC SHALL be ignored; IR and state SHALL not change.
REQ-020 EXEC: exec_valid = 1; opcode/rd/imm come from the IR and stay stable for the whole state.
REQ-021 EXEC with stall = 1: hold state, IR and pc; jmp_sel ignored.
REQ-022 EXEC with stall = 0 and jmp_sel = 1: pc <= {rd, imm} zero-extended or truncated to PC_W; next state FETCH.
REQ-023 EXEC with stall = 0 and jmp_sel = 0: pc <= pc + 1 modulo 2^PC_W, so all-ones wraps to 0; next state FETCH.
REQ-024 pc SHALL change only on the EXEC exit cycle.
REQ-025 Minimum instruction period: 3 cycles (FETCH, WAIT with immediate ack, EXEC).
REQ-026 imem_req SHALL be low in EXEC.
REQ-027 Simultaneous stall and jmp_sel: stall wins; the jump is taken on the first non-stalled EXEC cycle if jmp_sel is still high then.

Reset
REQ-028 While rst_n = 0: state = FETCH, pc = 0, IR = 0 (opcode = 0, rd = 0, imm = 0), exec_valid = 0, imem_req = 0.
REQ-029 Reset asserted mid-WAIT or mid-EXEC SHALL abort the instruction immediately; no pc update.
REQ-030 A pending imem_ack coincident with reset SHALL be discarded.
REQ-031 First imem_req SHALL rise in the first clock cycle after rst_n deasserts, with imem_addr = 0.

Structure
REQ-032 Shared package cpu_pkg SHALL hold the PC_W and INSTR_W defaults, the instruction field bit positions, and the FSM state enumeration.
REQ-033 The program counter with its increment/load logic SHALL be a sub-module pc_reg (inputs load, inc, load_val; output pc).
REQ-034 Top level instantiates pc_reg and contains the FSM and the IR; no combinational path from imem_rdata to opcode.

Verification
REQ-035 Reset release, ack on first WAIT cycle with rdata = 10'b0001_010_011, stall = 0, jmp_sel = 0 -> opcode = 4'b0001, rd = 3'b010, imm = 3'b011 in EXEC; pc goes from 0 to 1; next imem_addr = 1.
REQ-036 Ack delayed 4 cycles -> imem_req high for 5 consecutive cycles; exec_valid rises on the cycle after ack.
REQ-037 EXEC with jmp_sel = 1, rd = 3'b101, imm = 3'b110, PC_W = 6 -> pc = 6'b101110; next fetch address is 46.
REQ-038 pc = 63, no jump -> pc wraps to 0.
REQ-039 stall high for 3 EXEC cycles with jmp_sel toggling -> opcode, pc and exec_valid are held; the jump is resolved only on the cycle stall drops.
REQ-040 rst_n pulsed low during WAIT while ack arrives -> pc = 0, IR = 0, FSM restarts in FETCH with imem_addr = 0.
